// File: rtl/decode_ctrl_pipe_if.sv
// Decode-stage control bus: ID instruction and pipeline controls in,
// staged control bundles, EX instruction and load-use stall out.
interface decode_ctrl_pipe_if #(
    parameter int INSTR_W    = 32,
    parameter int PIPE_DEPTH = 3,
    parameter int CTRL_W     = 15
);
    logic [INSTR_W-1:0]           Instr;
    logic                         InstrValid;
    logic                         IFLUSH;
    logic                         Stall_in;
    logic [PIPE_DEPTH*CTRL_W-1:0] CtrlPipe;
    logic [INSTR_W-1:0]           IR_ex;
    logic                         HazardStall;

    modport master (
        output Instr, InstrValid, IFLUSH, Stall_in,
        input  CtrlPipe, IR_ex, HazardStall
    );

    modport slave (
        input  Instr, InstrValid, IFLUSH, Stall_in,
        output CtrlPipe, IR_ex, HazardStall
    );
endinterface

// File: rtl/decode_ctrl_pipe.sv
// MIPS decode-stage control unit: decodes ID, carries the control bundle through
// PIPE_DEPTH stages, detects load-use hazards. Define BRANCH_DECODE_EN to decode BEQ/BNE/J/JAL.
module decode_ctrl_pipe #(
    parameter int INSTR_W    = 32,
    parameter int PIPE_DEPTH = 3,
    parameter int CTRL_W     = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    decode_ctrl_pipe_if.slave bus
);
    localparam int B_REG_WRITE = 0;
    localparam int B_MEM_TO_REG = 1;
    localparam int B_MEM_READ  = 2;
    localparam int B_MEM_WRITE = 3;
    localparam int B_ALU_SRC   = 4;
    localparam int B_REG_DST   = 5;
    localparam int B_LD_BYTE   = 6;
    localparam int B_LD_BYTE_U = 7;
    localparam int B_LD_HALF   = 8;
    localparam int B_LD_WORD   = 9;
    localparam int B_ST_BYTE   = 10;
    localparam int B_ST_HALF   = 11;
    localparam int B_ST_WORD   = 12;
`ifdef BRANCH_DECODE_EN
    localparam int B_BRANCH    = 13;
    localparam int B_JUMP      = 14;
    localparam logic [CTRL_W-1:0] CTRL_MASK = '1;
`else
    // Branch/Jump bits never leave decode when branch decoding is compiled out.
    localparam logic [CTRL_W-1:0] CTRL_MASK = {{(CTRL_W-13){1'b0}}, 13'h1FFF};
`endif

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    logic [5:0]                   opcode;
    logic [4:0]                   id_rs;
    logic [4:0]                   id_rt;
    logic [4:0]                   ex_rt;
    logic [CTRL_W-1:0]            ctrl_dec;
    logic                         uses_rt;
    logic                         hazard;
    logic                         squash;
    logic [CTRL_W-1:0]            stage0_reg;
    logic [CTRL_W-1:0]            stage0_next;
    logic [INSTR_W-1:0]           ir_ex_reg;
    logic [INSTR_W-1:0]           ir_ex_next;
    logic [PIPE_DEPTH*CTRL_W-1:0] ctrl_pipe_q;

    assign opcode = bus.Instr[31:26];
    assign id_rs  = bus.Instr[25:21];
    assign id_rt  = bus.Instr[20:16];
    assign ex_rt  = ir_ex_reg[20:16];

    always_comb begin
        ctrl_dec = '0;
        uses_rt  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                ctrl_dec[B_REG_WRITE] = 1'b1;
                ctrl_dec[B_REG_DST]   = 1'b1;
                uses_rt               = 1'b1;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                ctrl_dec[B_REG_WRITE] = 1'b1;
                ctrl_dec[B_ALU_SRC]   = 1'b1;
            end
            OP_LB, OP_LH, OP_LBU, OP_LW: begin
                ctrl_dec[B_REG_WRITE]  = 1'b1;
                ctrl_dec[B_MEM_TO_REG] = 1'b1;
                ctrl_dec[B_MEM_READ]   = 1'b1;
                ctrl_dec[B_ALU_SRC]    = 1'b1;
                ctrl_dec[B_LD_BYTE]    = (opcode == OP_LB);
                ctrl_dec[B_LD_BYTE_U]  = (opcode == OP_LBU);
                ctrl_dec[B_LD_HALF]    = (opcode == OP_LH);
                ctrl_dec[B_LD_WORD]    = (opcode == OP_LW);
            end
            OP_SB, OP_SH, OP_SW: begin
                ctrl_dec[B_MEM_WRITE] = 1'b1;
                ctrl_dec[B_ALU_SRC]   = 1'b1;
                ctrl_dec[B_ST_BYTE]   = (opcode == OP_SB);
                ctrl_dec[B_ST_HALF]   = (opcode == OP_SH);
                ctrl_dec[B_ST_WORD]   = (opcode == OP_SW);
                uses_rt               = 1'b1;
            end
`ifdef BRANCH_DECODE_EN
            6'b000100, 6'b000101: begin
                ctrl_dec[B_BRANCH] = 1'b1;
                uses_rt            = 1'b1;
            end
            6'b000010: ctrl_dec[B_JUMP] = 1'b1;
            6'b000011: begin
                ctrl_dec[B_JUMP]      = 1'b1;
                ctrl_dec[B_REG_WRITE] = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    // A load sitting in EX whose destination feeds the ID instruction must wait one cycle.
    assign hazard = stage0_reg[B_MEM_READ] && (ex_rt != 5'd0) && bus.InstrValid &&
                    ((ex_rt == id_rs) || (uses_rt && (ex_rt == id_rt)));
    assign bus.HazardStall = hazard && !bus.IFLUSH;

    assign squash      = bus.IFLUSH || bus.HazardStall || !bus.InstrValid;
    assign stage0_next = squash ? '0 : (ctrl_dec & CTRL_MASK);
    assign ir_ex_next  = squash ? '0 : bus.Instr;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            stage0_reg <= '0;
            ir_ex_reg  <= '0;
        end else if (!bus.Stall_in) begin
            stage0_reg <= stage0_next;
            ir_ex_reg  <= ir_ex_next;
        end
    end

    assign ctrl_pipe_q[CTRL_W-1:0] = stage0_reg;

    genvar gi;
    generate
        for (gi = 1; gi < PIPE_DEPTH; gi++) begin : g_stage
            logic [CTRL_W-1:0] bundle_reg;

            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    bundle_reg <= '0;
                end else if (!bus.Stall_in) begin
                    bundle_reg <= ctrl_pipe_q[(gi-1)*CTRL_W +: CTRL_W];
                end
            end

            assign ctrl_pipe_q[gi*CTRL_W +: CTRL_W] = bundle_reg;
        end
    endgenerate

    assign bus.CtrlPipe = ctrl_pipe_q;
    assign bus.IR_ex    = ir_ex_reg;
endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Directed bench for decode_ctrl_pipe: opcode-table pipeline model checked every cycle
// plus literal bundle expectations. Honours BRANCH_DECODE_EN when defined.
module tb_decode_ctrl_pipe;
    localparam int INSTR_W    = 32;
    localparam int PIPE_DEPTH = 3;
    localparam int CTRL_W     = 15;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_SH   = 6'b101001;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

`ifdef BRANCH_DECODE_EN
    localparam logic [14:0] EXP_BEQ = 15'h2000;
`else
    localparam logic [14:0] EXP_BEQ = 15'h0000;
`endif

    logic Clock = 1'b0;
    logic Reset = 1'b0;
    always #5 Clock = ~Clock;

    decode_ctrl_pipe_if #(.INSTR_W(INSTR_W), .PIPE_DEPTH(PIPE_DEPTH), .CTRL_W(CTRL_W)) bus ();

    decode_ctrl_pipe #(.INSTR_W(INSTR_W), .PIPE_DEPTH(PIPE_DEPTH), .CTRL_W(CTRL_W)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    logic [CTRL_W-1:0]  m_stage [PIPE_DEPTH];
    logic [INSTR_W-1:0] m_ir;

    // Expected bundle per opcode, written as the hex value of the listed control bits.
    function automatic logic [CTRL_W-1:0] model_decode(input logic [5:0] op);
        if (op == OP_R) return 15'h0021;
        if (op[5:3] == 3'b001) return 15'h0011;
        case (op)
            OP_LB:  return 15'h0057;
            OP_LH:  return 15'h0117;
            OP_LBU: return 15'h0097;
            OP_LW:  return 15'h0217;
            OP_SB:  return 15'h0418;
            OP_SH:  return 15'h0818;
            OP_SW:  return 15'h1018;
`ifdef BRANCH_DECODE_EN
            OP_BEQ, OP_BNE: return 15'h2000;
            OP_J:   return 15'h4000;
            OP_JAL: return 15'h4001;
`endif
            default: return 15'h0000;
        endcase
    endfunction

    function automatic logic model_reads_rt(input logic [5:0] op);
        logic r;
        r = (op == OP_R) || (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
`ifdef BRANCH_DECODE_EN
        r = r || (op == OP_BEQ) || (op == OP_BNE);
`endif
        return r;
    endfunction

    function automatic logic model_hazard();
        logic [4:0] load_rt;
        logic       is_load;
        load_rt = m_ir[20:16];
        is_load = (m_stage[0] & 15'h0004) != 15'h0000;
        if (!is_load || load_rt == 5'd0 || !bus.InstrValid || bus.IFLUSH) return 1'b0;
        return (load_rt == bus.Instr[25:21]) ||
               (model_reads_rt(bus.Instr[31:26]) && load_rt == bus.Instr[20:16]);
    endfunction

    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) m_stage[i] <= '0;
            m_ir <= '0;
        end else if (!bus.Stall_in) begin
            for (int i = 1; i < PIPE_DEPTH; i++) m_stage[i] <= m_stage[i-1];
            if (bus.IFLUSH || model_hazard() || !bus.InstrValid) begin
                m_stage[0] <= '0;
                m_ir       <= '0;
            end else begin
                m_stage[0] <= model_decode(bus.Instr[31:26]);
                m_ir       <= bus.Instr;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        logic [PIPE_DEPTH*CTRL_W-1:0] exp_vec;
        if ($time > 2) begin
            for (int i = 0; i < PIPE_DEPTH; i++) exp_vec[i*CTRL_W +: CTRL_W] = m_stage[i];
            check("model_ctrlpipe", 64'(bus.CtrlPipe), 64'(exp_vec));
            check("model_ir_ex", 64'(bus.IR_ex), 64'(m_ir));
            check("model_hazard", 64'(bus.HazardStall), 64'(model_hazard()));
        end
    end

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt);
        return {op, rs, rt, 16'h1020};
    endfunction

    function automatic logic [CTRL_W-1:0] stage(input int k);
        return bus.CtrlPipe[k*CTRL_W +: CTRL_W];
    endfunction

    task automatic drive(input logic [31:0] instr, input logic v, input logic f, input logic s);
        bus.Instr      = instr;
        bus.InstrValid = v;
        bus.IFLUSH     = f;
        bus.Stall_in   = s;
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
        $display("[TB] t=%0t in=%h v=%0b f=%0b s=%0b -> ex=%h mem=%h wb=%h ir_ex=%h haz=%0b",
                 $time, bus.Instr, bus.InstrValid, bus.IFLUSH, bus.Stall_in,
                 stage(0), stage(1), stage(2), bus.IR_ex, bus.HazardStall);
    endtask

    initial begin
        drive(32'h0, 1'b0, 1'b0, 1'b0);
        #1 Reset = 1'b1;
        @(posedge Clock);
        @(posedge Clock);
        #1;
        check("reset_ctrlpipe", 64'(bus.CtrlPipe), 64'h0);
        check("reset_ir_ex", 64'(bus.IR_ex), 64'h0);
        check("reset_hazard", 64'(bus.HazardStall), 64'h0);
        Reset = 1'b0;

        // Load-use: LW $1 then ADD $2,$1,$3
        drive(mk(OP_LW, 5'd2, 5'd1), 1'b1, 1'b0, 1'b0); tick();
        check("lw_stage0", 64'(stage(0)), 64'h0217);
        drive(mk(OP_R, 5'd1, 5'd3), 1'b1, 1'b0, 1'b0); #1;
        check("loaduse_hazard", 64'(bus.HazardStall), 64'h1);
        tick();
        check("loaduse_bubble", 64'(stage(0)), 64'h0000);
        check("loaduse_lw_mem", 64'(stage(1)), 64'h0217);
        check("loaduse_released", 64'(bus.HazardStall), 64'h0);
        tick();
        check("add_stage0", 64'(stage(0)), 64'h0021);

        // SW marching through the stages
        drive(mk(OP_SW, 5'd4, 5'd5), 1'b1, 1'b0, 1'b0); tick();
        check("sw_stage0", 64'(stage(0)), 64'h1018);
        drive(32'h0, 1'b0, 1'b0, 1'b0); tick();
        check("sw_stage1", 64'(stage(1)), 64'h1018);
        tick();
        check("sw_stage2", 64'(stage(2)), 64'h1018);

        // ORI squashed, then accepted
        drive(mk(OP_ORI, 5'd1, 5'd2), 1'b1, 1'b1, 1'b0); tick();
        check("ori_flushed", 64'(stage(0)), 64'h0000);
        drive(mk(OP_ORI, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0); tick();
        check("ori_stage0", 64'(stage(0)), 64'h0011);
        check("ori_ir_ex", 64'(bus.IR_ex), 64'(mk(OP_ORI, 5'd1, 5'd2)));

        // LB held by Stall_in for three cycles, IFLUSH pending alongside
        drive(mk(OP_LB, 5'd3, 5'd9), 1'b1, 1'b0, 1'b0); tick();
        check("lb_stage0", 64'(stage(0)), 64'h0057);
        drive(mk(OP_R, 5'd9, 5'd9), 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_stage0", 64'(stage(0)), 64'h0057);
            check("stall_stage1", 64'(stage(1)), 64'h0011);
        end
        check("stall_flush_nohaz", 64'(bus.HazardStall), 64'h0);
        drive(32'h0, 1'b0, 1'b0, 1'b0); tick();
        check("unstall_stage1", 64'(stage(1)), 64'h0057);
        check("unstall_stage0", 64'(stage(0)), 64'h0000);

        // rt=0 load never stalls
        drive(mk(OP_LW, 5'd1, 5'd0), 1'b1, 1'b0, 1'b0); tick();
        drive(mk(OP_R, 5'd0, 5'd0), 1'b1, 1'b0, 1'b0); #1;
        check("rt0_nohaz", 64'(bus.HazardStall), 64'h0);
        tick();
        check("rt0_add", 64'(stage(0)), 64'h0021);

        // IFLUSH together with a hazard: bubble, no stall
        drive(mk(OP_LW, 5'd1, 5'd5), 1'b1, 1'b0, 1'b0); tick();
        drive(mk(OP_R, 5'd5, 5'd6), 1'b1, 1'b1, 1'b0); #1;
        check("flush_haz_nostall", 64'(bus.HazardStall), 64'h0);
        tick();
        check("flush_haz_bubble", 64'(stage(0)), 64'h0000);

        // Back-to-back dependent loads: one bubble each
        drive(mk(OP_LW, 5'd1, 5'd4), 1'b1, 1'b0, 1'b0); tick();
        drive(mk(OP_LW, 5'd4, 5'd6), 1'b1, 1'b0, 1'b0); #1;
        check("b2b_haz1", 64'(bus.HazardStall), 64'h1);
        tick();
        check("b2b_bubble1", 64'(stage(0)), 64'h0000);
        tick();
        check("b2b_lw2", 64'(stage(0)), 64'h0217);
        drive(mk(OP_LW, 5'd6, 5'd7), 1'b1, 1'b0, 1'b0); #1;
        check("b2b_haz2", 64'(bus.HazardStall), 64'h1);
        tick(); tick();
        check("b2b_lw3_ir", 64'(bus.IR_ex), 64'(mk(OP_LW, 5'd6, 5'd7)));

        // Store depends through rt; ADDI rt is a destination, not a source
        drive(mk(OP_SW, 5'd9, 5'd7), 1'b1, 1'b0, 1'b0); #1;
        check("sw_rt_haz", 64'(bus.HazardStall), 64'h1);
        tick(); tick();
        drive(mk(OP_LW, 5'd1, 5'd8), 1'b1, 1'b0, 1'b0); tick();
        drive(mk(OP_ADDI, 5'd10, 5'd8), 1'b1, 1'b0, 1'b0); #1;
        check("addi_rt_nohaz", 64'(bus.HazardStall), 64'h0);
        tick();
        check("addi_stage0", 64'(stage(0)), 64'h0011);

        // Remaining opcodes, checked by the model
        drive(mk(OP_LH, 5'd11, 5'd12), 1'b1, 1'b0, 1'b0); tick();
        drive(mk(OP_LBU, 5'd13, 5'd14), 1'b1, 1'b0, 1'b0); tick();
        drive(mk(OP_SB, 5'd14, 5'd15), 1'b1, 1'b0, 1'b0); tick(); tick();
        drive(mk(OP_SH, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0); tick();
        drive(mk(6'b111111, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0); tick();
        check("unknown_bubble", 64'(stage(0)), 64'h0000);
        drive(mk(OP_BEQ, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0); tick();
        check("beq_stage0", 64'(stage(0)), 64'(EXP_BEQ));
        drive(mk(OP_J, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0); tick();
        drive(mk(OP_JAL, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0); tick();
        drive(mk(OP_LW, 5'd1, 5'd3), 1'b1, 1'b0, 1'b0); tick();
        drive(mk(OP_BNE, 5'd2, 5'd3), 1'b1, 1'b0, 1'b0); tick(); tick();

        // Reset in the middle of a stall
        drive(mk(OP_ORI, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0); tick();
        drive(mk(OP_ORI, 5'd1, 5'd2), 1'b1, 1'b0, 1'b1); tick();
        #1 Reset = 1'b1;
        #1;
        check("midreset_ctrlpipe", 64'(bus.CtrlPipe), 64'h0);
        check("midreset_ir_ex", 64'(bus.IR_ex), 64'h0);
        check("midreset_hazard", 64'(bus.HazardStall), 64'h0);
        #1 Reset = 1'b0;
        drive(mk(OP_ORI, 5'd1, 5'd2), 1'b1, 1'b0, 1'b0);
        tick();
        check("post_reset_stage0", 64'(stage(0)), 64'h0011);
        check("post_reset_stage1", 64'(stage(1)), 64'h0000);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
